// File: rtl/ip_rx_pkg.sv
// Shared types and constants for the IPv4/Ethernet receive parser.
package ip_rx_pkg;

    typedef enum logic [2:0] {
        ST_GET_ETH_HDR   = 3'd0,
        ST_GET_IP_HDR    = 3'd1,
        ST_GET_USER_DATA = 3'd2,
        ST_WAIT_FOR_END  = 3'd3,
        ST_HOLD_FRAME    = 3'd4
    } rx_state_t;

    localparam int          ETH_HDR_BYTES  = 14;
    localparam int          IP_HDR_BYTES   = 20;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;

    // Byte offsets inside the stored headers.
    localparam int ETH_DST_MAC_OFS = 0;
    localparam int ETH_SRC_MAC_OFS = 6;
    localparam int ETH_TYPE_OFS    = 12;
    localparam int IP_VER_IHL_OFS  = 0;
    localparam int IP_SRC_IP_OFS   = 12;
    localparam int IP_DST_IP_OFS   = 16;

    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/ip_hdr_csum_accum.sv
// Running ones-complement sum of the IPv4 header, one byte per beat.
// Even header bytes form the high half of a big-endian 16-bit word, odd bytes
// the low half; each addition folds its carry back in (end-around carry).
module ip_hdr_csum_accum (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_en,
    input  logic        i_hi_byte,
    input  logic        i_clear,
    output logic [15:0] o_sum
);

    logic [15:0] r_sum;
    logic [15:0] w_word;
    logic [16:0] w_add;

    assign w_word = i_hi_byte ? {i_byte, 8'h00} : {8'h00, i_byte};
    assign w_add  = {1'b0, r_sum} + {1'b0, w_word};
    assign o_sum  = r_sum;

    // Accumulate with end-around carry; cleared between packets.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sum <= '0;
        end else if (i_byte_en) begin
            r_sum <= w_add[15:0] + {15'd0, w_add[16]};
        end
    end

endmodule

// File: rtl/ip_packet_rx_param.sv
// IPv4/Ethernet receive parser: strips headers, filters, captures a fixed-size
// payload and holds it for the consumer with a valid/ack handshake.
// Optional header checksum filter: define IP_PACKET_RX_CSUM_CHECK_EN.
//
// state            | meaning
// ST_GET_ETH_HDR   | collecting 14 Ethernet header bytes (reset state)
// ST_GET_IP_HDR    | collecting 20 IPv4 header bytes
// ST_GET_USER_DATA | collecting payload, filter decision on the last byte
// ST_WAIT_FOR_END  | oversize frame dropped, discarding until LAST
// ST_HOLD_FRAME    | frame presented, MAC stalled until FRAME_ACK
module ip_packet_rx_param
    import ip_rx_pkg::*;
#(
    parameter int USER_DATA_BYTES = 785,
    parameter int COUNTER_WIDTH   = 16,
    parameter bit CHECK_DST_MAC   = 1'b1,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [31:0]                  ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]                  ACCELERATOR_MAC_ADDRESS,
    input  logic [7:0]                   MAC_DATA_OUT,
    input  logic                         MAC_DATA_VALID,
    output logic                         MAC_DATA_READY,
    input  logic                         MAC_DATA_LAST,
    input  logic                         MAC_DATA_TUSER,
    output logic [USER_DATA_BYTES*8-1:0] DATA_FRAME,
    output logic [31:0]                  SRC_IP_ADDRESS,
    output logic [47:0]                  SRC_MAC_ADDRESS,
    output logic                         FRAME_VALID,
    input  logic                         FRAME_ACK,
    output logic                         PACKET_FOR_ACCELERATOR,
    output logic [DROP_CNT_WIDTH-1:0]    DROP_COUNT
);

    rx_state_t                    r_state, w_next_state;
    logic [COUNTER_WIDTH-1:0]     r_count;
    logic [ETH_HDR_BYTES*8-1:0]   r_eth_hdr;
    logic [IP_HDR_BYTES*8-1:0]    r_ip_hdr;
    logic [USER_DATA_BYTES*8-1:0] r_data_frame;
    logic [31:0]                  r_src_ip;
    logic [47:0]                  r_src_mac;
    logic                         r_frame_valid;
    logic [DROP_CNT_WIDTH-1:0]    r_drop_count;

    logic        w_ready, w_beat, w_drop, w_accept, w_last_payload;
    logic        w_filters_ok, w_mac_ok, w_csum_ok;
    logic [15:0] w_ethertype;
    logic [47:0] w_dst_mac;
    logic [31:0] w_dst_ip;
    logic        w_unused_hdr;

    assign w_ready        = (r_state != ST_HOLD_FRAME);
    assign w_beat         = MAC_DATA_VALID & w_ready;
    assign w_last_payload = (r_count == COUNTER_WIDTH'(USER_DATA_BYTES - 1));

    assign w_ethertype  = {r_eth_hdr[ETH_TYPE_OFS*8 +: 8], r_eth_hdr[(ETH_TYPE_OFS+1)*8 +: 8]};
    assign w_dst_mac    = r_eth_hdr[ETH_DST_MAC_OFS*8 +: 48];
    assign w_dst_ip     = r_ip_hdr[IP_DST_IP_OFS*8 +: 32];
    assign w_mac_ok     = !CHECK_DST_MAC || (w_dst_mac == ACCELERATOR_MAC_ADDRESS) ||
                          (w_dst_mac == BROADCAST_MAC);
    assign w_filters_ok = (w_ethertype == ETHERTYPE_IPV4) &&
                          (r_ip_hdr[IP_VER_IHL_OFS*8 +: 8] == IP_VER_IHL) &&
                          (w_dst_ip == ACCELERATOR_IP_ADDRESS) && w_mac_ok && w_csum_ok;
    // Length/TTL/protocol/checksum fields are carried but never inspected.
    assign w_unused_hdr = ^r_ip_hdr[IP_SRC_IP_OFS*8-1:8];

`ifdef IP_PACKET_RX_CSUM_CHECK_EN
    logic [15:0] w_csum;

    ip_hdr_csum_accum u_csum (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_byte    (MAC_DATA_OUT),
        .i_byte_en (w_beat && (r_state == ST_GET_IP_HDR)),
        .i_hi_byte (~r_count[0]),
        .i_clear   (r_state == ST_GET_ETH_HDR),
        .o_sum     (w_csum)
    );

    assign w_csum_ok = (w_csum == 16'hFFFF);
`else
    assign w_csum_ok = 1'b1;
`endif

    // Next-state decode plus drop/accept strobes for the current beat.
    always_comb begin
        w_next_state = r_state;
        w_drop       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_GET_ETH_HDR: if (w_beat) begin
                if (MAC_DATA_LAST) begin
                    w_drop       = 1'b1;
                    w_next_state = ST_GET_ETH_HDR;
                end else if (r_count == COUNTER_WIDTH'(ETH_HDR_BYTES - 1)) begin
                    w_next_state = ST_GET_IP_HDR;
                end
            end
            ST_GET_IP_HDR: if (w_beat) begin
                if (MAC_DATA_LAST) begin
                    w_drop       = 1'b1;
                    w_next_state = ST_GET_ETH_HDR;
                end else if (r_count == COUNTER_WIDTH'(IP_HDR_BYTES - 1)) begin
                    w_next_state = ST_GET_USER_DATA;
                end
            end
            ST_GET_USER_DATA: if (w_beat) begin
                if (w_last_payload) begin
                    if (MAC_DATA_LAST && !MAC_DATA_TUSER && w_filters_ok) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_HOLD_FRAME;
                    end else begin
                        w_drop       = 1'b1;
                        w_next_state = MAC_DATA_LAST ? ST_GET_ETH_HDR : ST_WAIT_FOR_END;
                    end
                end else if (MAC_DATA_LAST) begin
                    w_drop       = 1'b1;
                    w_next_state = ST_GET_ETH_HDR;
                end
            end
            ST_WAIT_FOR_END: if (w_beat && MAC_DATA_LAST) begin
                w_next_state = ST_GET_ETH_HDR;
            end
            ST_HOLD_FRAME: if (FRAME_ACK) begin
                w_next_state = ST_GET_ETH_HDR;
            end
            default: w_next_state = ST_GET_ETH_HDR;
        endcase
    end

    // State, byte counter, frame-valid flag and drop counter.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= ST_GET_ETH_HDR;
            r_count       <= '0;
            r_frame_valid <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            r_state       <= w_next_state;
            r_frame_valid <= (w_next_state == ST_HOLD_FRAME);
            if (w_next_state != r_state) begin
                r_count <= '0;
            end else if (w_beat) begin
                r_count <= r_count + 1'b1;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    // Header/payload byte capture and sender address latch on accept.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_eth_hdr    <= '0;
            r_ip_hdr     <= '0;
            r_data_frame <= '0;
            r_src_ip     <= '0;
            r_src_mac    <= '0;
        end else begin
            if (w_beat && (r_state == ST_GET_ETH_HDR)) begin
                for (int i = 0; i < ETH_HDR_BYTES; i++) begin
                    if (r_count == COUNTER_WIDTH'(i)) r_eth_hdr[i*8 +: 8] <= MAC_DATA_OUT;
                end
            end
            if (w_beat && (r_state == ST_GET_IP_HDR)) begin
                for (int i = 0; i < IP_HDR_BYTES; i++) begin
                    if (r_count == COUNTER_WIDTH'(i)) r_ip_hdr[i*8 +: 8] <= MAC_DATA_OUT;
                end
            end
            if (w_beat && (r_state == ST_GET_USER_DATA)) begin
                for (int i = 0; i < USER_DATA_BYTES; i++) begin
                    if (r_count == COUNTER_WIDTH'(i)) r_data_frame[i*8 +: 8] <= MAC_DATA_OUT;
                end
            end
            if (w_accept) begin
                r_src_ip  <= r_ip_hdr[IP_SRC_IP_OFS*8 +: 32];
                r_src_mac <= r_eth_hdr[ETH_SRC_MAC_OFS*8 +: 48];
            end
        end
    end

    assign MAC_DATA_READY         = w_ready;
    assign FRAME_VALID            = r_frame_valid;
    assign DATA_FRAME             = r_data_frame;
    assign SRC_IP_ADDRESS         = r_src_ip;
    assign SRC_MAC_ADDRESS        = r_src_mac;
    assign DROP_COUNT             = r_drop_count;
    assign PACKET_FOR_ACCELERATOR = (w_dst_ip == ACCELERATOR_IP_ADDRESS);

endmodule

// File: tb/tb_ip_packet_rx_param.sv
// Scoreboard bench for ip_packet_rx_param: the packet driver pushes expected
// frames, a monitor pops and checks whenever FRAME_VALID rises, then acks.
module tb_ip_packet_rx_param;

    localparam int UDB = 785;

    localparam logic [31:0] LOCAL_IP  = 32'h0200_000A;     // 10.0.0.2
    localparam logic [31:0] OTHER_IP  = 32'h0900_000A;     // 10.0.0.9
    localparam logic [31:0] SENDER_IP = 32'h0700_000A;     // 10.0.0.7
    localparam logic [47:0] LOCAL_MAC = 48'h01_00_00_00_00_02;
    localparam logic [47:0] OTHER_MAC = 48'h05_00_00_00_00_02;
    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SENDER_MAC = 48'h01_00_EF_BE_AD_DE;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic [7:0] MAC_DATA_OUT = '0;
    logic MAC_DATA_VALID = 1'b0, MAC_DATA_LAST = 1'b0, MAC_DATA_TUSER = 1'b0;
    logic FRAME_ACK;
    logic MAC_DATA_READY, FRAME_VALID, PACKET_FOR_ACCELERATOR;
    logic [UDB*8-1:0] DATA_FRAME;
    logic [31:0] SRC_IP_ADDRESS;
    logic [47:0] SRC_MAC_ADDRESS;
    logic [15:0] DROP_COUNT;

    logic sat_ready, sat_valid, sat_pfa;
    logic [UDB*8-1:0] sat_frame;
    logic [31:0] sat_src_ip;
    logic [47:0] sat_src_mac;
    logic [1:0] sat_drop;

    always #5 ACLK = ~ACLK;

    ip_packet_rx_param #(.USER_DATA_BYTES(UDB), .COUNTER_WIDTH(16),
                         .CHECK_DST_MAC(1'b1), .DROP_CNT_WIDTH(16)) u_dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ACCELERATOR_IP_ADDRESS(LOCAL_IP), .ACCELERATOR_MAC_ADDRESS(LOCAL_MAC),
        .MAC_DATA_OUT(MAC_DATA_OUT), .MAC_DATA_VALID(MAC_DATA_VALID),
        .MAC_DATA_READY(MAC_DATA_READY), .MAC_DATA_LAST(MAC_DATA_LAST),
        .MAC_DATA_TUSER(MAC_DATA_TUSER), .DATA_FRAME(DATA_FRAME),
        .SRC_IP_ADDRESS(SRC_IP_ADDRESS), .SRC_MAC_ADDRESS(SRC_MAC_ADDRESS),
        .FRAME_VALID(FRAME_VALID), .FRAME_ACK(FRAME_ACK),
        .PACKET_FOR_ACCELERATOR(PACKET_FOR_ACCELERATOR), .DROP_COUNT(DROP_COUNT));

    // Same stream into a 2-bit drop counter instance to observe saturation.
    ip_packet_rx_param #(.USER_DATA_BYTES(UDB), .COUNTER_WIDTH(16),
                         .CHECK_DST_MAC(1'b1), .DROP_CNT_WIDTH(2)) u_sat (
        .ACLK(ACLK), .ARESET(ARESET),
        .ACCELERATOR_IP_ADDRESS(LOCAL_IP), .ACCELERATOR_MAC_ADDRESS(LOCAL_MAC),
        .MAC_DATA_OUT(MAC_DATA_OUT), .MAC_DATA_VALID(MAC_DATA_VALID),
        .MAC_DATA_READY(sat_ready), .MAC_DATA_LAST(MAC_DATA_LAST),
        .MAC_DATA_TUSER(MAC_DATA_TUSER), .DATA_FRAME(sat_frame),
        .SRC_IP_ADDRESS(sat_src_ip), .SRC_MAC_ADDRESS(sat_src_mac),
        .FRAME_VALID(sat_valid), .FRAME_ACK(FRAME_ACK),
        .PACKET_FOR_ACCELERATOR(sat_pfa), .DROP_COUNT(sat_drop));

    typedef struct {
        logic [7:0]  seed;
        logic [31:0] sip;
        logic [47:0] smac;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pay_byte(input logic [7:0] seed, input int i);
        return seed + 8'(i * 3);
    endfunction

    // Build one frame and drive it beat by beat; last_idx >= 0 truncates it
    // with LAST on that overall byte index.
    task automatic send_pkt(input logic [47:0] dmac, input logic [15:0] etype,
                            input logic [31:0] dip, input int plen, input int last_idx,
                            input bit tuser, input bit bad_csum, input bit expect_ok,
                            input logic [7:0] seed);
        logic [7:0]  b[$];
        logic [7:0]  ip[20];
        int unsigned sum;
        logic [15:0] cs;
        int          n;
        int          t;
        exp_t        e;
        for (int k = 0; k < 6; k++) b.push_back(dmac[k*8 +: 8]);
        for (int k = 0; k < 6; k++) b.push_back(SENDER_MAC[k*8 +: 8]);
        b.push_back(etype[15:8]);
        b.push_back(etype[7:0]);
        for (int k = 0; k < 20; k++) ip[k] = 8'h00;
        ip[0] = 8'h45;
        ip[2] = 8'(((20 + plen) >> 8) & 255);
        ip[3] = 8'((20 + plen) & 255);
        ip[8] = 8'd64;
        ip[9] = 8'd17;
        for (int k = 0; k < 4; k++) begin
            ip[12+k] = SENDER_IP[k*8 +: 8];
            ip[16+k] = dip[k*8 +: 8];
        end
        sum = 0;
        for (int w = 0; w < 10; w++) sum += {16'h0, ip[2*w], ip[2*w+1]};
        while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
        cs = ~sum[15:0];
        if (bad_csum) cs = cs ^ 16'h0001;
        ip[10] = cs[15:8];
        ip[11] = cs[7:0];
        for (int k = 0; k < 20; k++) b.push_back(ip[k]);
        for (int k = 0; k < plen; k++) b.push_back(pay_byte(seed, k));
        n = (last_idx >= 0) ? last_idx + 1 : b.size();
        if (expect_ok) begin
            e.seed = seed; e.sip = SENDER_IP; e.smac = SENDER_MAC;
            sb.push_back(e);
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge ACLK);
            MAC_DATA_OUT   = b[i];
            MAC_DATA_VALID = 1'b1;
            MAC_DATA_LAST  = (i == n - 1);
            MAC_DATA_TUSER = tuser && (i == n - 1);
            t = 0;
            while (!MAC_DATA_READY && t < 4000) begin
                @(negedge ACLK);
                t++;
            end
            if (t >= 4000) check("ready_timeout", 64'(MAC_DATA_READY), 64'd1);
            @(posedge ACLK);
        end
        @(negedge ACLK);
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_TUSER = 1'b0;
        check("valid_after_last", 64'(FRAME_VALID), 64'(expect_ok));
        check("drop_count", 64'(DROP_COUNT), 64'(exp_drop));
        check("drop_count_sat", 64'(sat_drop), 64'((exp_drop > 3) ? 3 : exp_drop));
        if (!expect_ok) check("ready_after_drop", 64'(MAC_DATA_READY), 64'd1);
    endtask

    // Monitor: compare each presented frame against the scoreboard, then ack.
    initial begin
        exp_t e;
        int   bad_idx;
        FRAME_ACK = 1'b0;
        forever begin
            @(negedge ACLK);
            if (FRAME_VALID === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", 64'(FRAME_VALID), 64'd0);
                end else begin
                    e = sb.pop_front();
                    bad_idx = -1;
                    for (int i = 0; i < UDB; i++) begin
                        if (bad_idx < 0 && DATA_FRAME[i*8 +: 8] !== pay_byte(e.seed, i)) bad_idx = i;
                    end
                    n_cmp++;
                    if (bad_idx >= 0) begin
                        n_bad++;
                        $display("FAIL data_frame byte %0d: got %0h, expected %0h", bad_idx,
                                 DATA_FRAME[bad_idx*8 +: 8], pay_byte(e.seed, bad_idx));
                    end
                    check("src_ip", 64'(SRC_IP_ADDRESS), 64'(e.sip));
                    check("src_mac", 64'(SRC_MAC_ADDRESS), 64'(e.smac));
                    check("ready_in_hold", 64'(MAC_DATA_READY), 64'd0);
                    check("pkt_for_accel", 64'(PACKET_FOR_ACCELERATOR), 64'd1);
                end
                repeat (3) @(negedge ACLK);
                check("valid_held", 64'(FRAME_VALID), 64'd1);
                check("first_byte_stable", 64'(DATA_FRAME[7:0]), 64'(e.seed));
                FRAME_ACK = 1'b1;
                @(negedge ACLK);
                FRAME_ACK = 1'b0;
                check("valid_after_ack", 64'(FRAME_VALID), 64'd0);
                check("ready_after_ack", 64'(MAC_DATA_READY), 64'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        check("rst_frame_valid", 64'(FRAME_VALID), 64'd0);
        check("rst_ready", 64'(MAC_DATA_READY), 64'd1);
        check("rst_drop", 64'(DROP_COUNT), 64'd0);
        check("rst_src_ip", 64'(SRC_IP_ADDRESS), 64'd0);
        check("rst_src_mac", 64'(SRC_MAC_ADDRESS), 64'd0);
        check("rst_payload", 64'(DATA_FRAME[7:0]), 64'd0);
        check("rst_pkt_for_accel", 64'(PACKET_FOR_ACCELERATOR), 64'd0);

        // Good packet, then wrong destination IP.
        send_pkt(LOCAL_MAC, 16'h0800, LOCAL_IP, UDB, -1, 1'b0, 1'b0, 1'b1, 8'h11);
        check("pfa_match", 64'(PACKET_FOR_ACCELERATOR), 64'd1);
        send_pkt(LOCAL_MAC, 16'h0800, OTHER_IP, UDB, -1, 1'b0, 1'b0, 1'b0, 8'h22);
        check("pfa_mismatch", 64'(PACKET_FOR_ACCELERATOR), 64'd0);

        // Runt in payload (LAST on payload byte 100), then a good packet.
        send_pkt(LOCAL_MAC, 16'h0800, LOCAL_IP, UDB, 34 + 100, 1'b0, 1'b0, 1'b0, 8'h33);
        send_pkt(LOCAL_MAC, 16'h0800, LOCAL_IP, UDB, -1, 1'b0, 1'b0, 1'b1, 8'h34);

        // Oversize payload, then a back-to-back good packet.
        send_pkt(LOCAL_MAC, 16'h0800, LOCAL_IP, 900, -1, 1'b0, 1'b0, 1'b0, 8'h44);
        send_pkt(LOCAL_MAC, 16'h0800, LOCAL_IP, UDB, -1, 1'b0, 1'b0, 1'b1, 8'h45);

        // Errored frame and ARP EtherType; 2-bit counter reaches its ceiling.
        send_pkt(LOCAL_MAC, 16'h0800, LOCAL_IP, UDB, -1, 1'b1, 1'b0, 1'b0, 8'h55);
        send_pkt(LOCAL_MAC, 16'h0806, LOCAL_IP, UDB, -1, 1'b0, 1'b0, 1'b0, 8'h56);

        // Broadcast accepted, foreign MAC dropped, header runt dropped.
        send_pkt(BCAST_MAC, 16'h0800, LOCAL_IP, UDB, -1, 1'b0, 1'b0, 1'b1, 8'h66);
        send_pkt(OTHER_MAC, 16'h0800, LOCAL_IP, UDB, -1, 1'b0, 1'b0, 1'b0, 8'h67);
        send_pkt(LOCAL_MAC, 16'h0800, LOCAL_IP, UDB, 10, 1'b0, 1'b0, 1'b0, 8'h68);

`ifdef IP_PACKET_RX_CSUM_CHECK_EN
        send_pkt(LOCAL_MAC, 16'h0800, LOCAL_IP, UDB, -1, 1'b0, 1'b1, 1'b0, 8'h77);
        send_pkt(LOCAL_MAC, 16'h0800, LOCAL_IP, UDB, -1, 1'b0, 1'b0, 1'b1, 8'h78);
`endif

        repeat (12) @(negedge ACLK);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
